// File: rtl/bus_seq_arbiter.sv
// Round-robin arbiter sharing one bus sequencer between NUM_REQ requesters,
// with per-owner read routing and a saturating watchdog on stalled jobs.
module bus_seq_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        done_o,
  output logic [NUM_REQ-1:0]        err_o,
  output logic [NUM_REQ-1:0]        rd_valid_o,
  output logic [7:0]                rd_data_o,
  output logic                      busy_o,
  output logic                      seq_start_o,
  output logic [ADDR_W-1:0]         seq_start_addr_o,
  input  logic                      seq_ready_i,
  input  logic                      seq_data_valid_i,
  input  logic [7:0]                seq_data_i
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_ACK,
    RUN,
    DONE
  } state_t;

  state_t            state_q, next_state;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  owner_q, owner_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              to_q, to_d;
  logic [PTR_W:0]    pick;
  logic [ADDR_W-1:0] addr_sel;
  logic              wd_expired;
  logic              rd_hit;

  // {found, index} of the first request at or after ptr, wrapping.
  function automatic logic [PTR_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                             input logic [PTR_W-1:0]   ptr);
    logic             found;
    logic [PTR_W-1:0] win;
    logic [PTR_W-1:0] idx_w;
    int               idx;
    found = 1'b0;
    win   = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_w = PTR_W'(idx);
      if (!found && req[idx_w]) begin
        found = 1'b1;
        win   = idx_w;
      end
    end
    return {found, win};
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [WD_W-1:0] wd_sat_inc(input logic [WD_W-1:0] w);
    return (w == WD_LIMIT) ? w : w + WD_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] o);
    return (o == PTR_W'(NUM_REQ - 1)) ? '0 : o + PTR_W'(1);
  endfunction

  assign pick       = rr_pick(req_i, ptr_q);
  assign wd_expired = (TIMEOUT_CYC != 0) && (wd_q == WD_LIMIT);
  assign rd_hit     = seq_data_valid_i && ((state_q == WAIT_ACK) || (state_q == RUN));

  always_comb begin
    addr_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[PTR_W-1:0] == PTR_W'(i)) addr_sel = req_addr_i[i*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    next_state = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    wd_d       = wd_q;
    to_d       = to_q;
    case (state_q)
      IDLE: begin
        if (seq_ready_i && pick[PTR_W]) begin
          next_state = START;
          owner_d    = pick[PTR_W-1:0];
          to_d       = 1'b0;
        end
      end
      START: begin
        next_state = WAIT_ACK;
        wd_d       = '0;
      end
      WAIT_ACK: begin
        if (!seq_ready_i) begin
          next_state = RUN;
          wd_d       = '0;
        end else if (wd_expired) begin
          next_state = DONE;
          to_d       = 1'b1;
        end else begin
          wd_d = wd_sat_inc(wd_q);
        end
      end
      RUN: begin
        if (seq_ready_i) begin
          next_state = DONE;
        end else if (wd_expired) begin
          next_state = DONE;
          to_d       = 1'b1;
        end else begin
          wd_d = wd_sat_inc(wd_q);
        end
      end
      DONE: begin
        next_state = IDLE;
        ptr_d      = ptr_after(owner_q);
      end
      default: next_state = IDLE;
    endcase
  end

  // Control state and registered outputs, all driven from next-state values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      ptr_q            <= '0;
      owner_q          <= '0;
      wd_q             <= '0;
      to_q             <= 1'b0;
      gnt_o            <= '0;
      done_o           <= '0;
      err_o            <= '0;
      busy_o           <= 1'b0;
      seq_start_o      <= 1'b0;
      seq_start_addr_o <= '0;
      rd_valid_o       <= '0;
      rd_data_o        <= '0;
    end else begin
      state_q     <= next_state;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      wd_q        <= wd_d;
      to_q        <= to_d;
      gnt_o       <= (next_state != IDLE) ? onehot(owner_d) : '0;
      done_o      <= (next_state == DONE) ? onehot(owner_d) : '0;
      err_o       <= ((next_state == DONE) && to_d) ? onehot(owner_d) : '0;
      busy_o      <= (next_state != IDLE);
      seq_start_o <= (next_state == START);
      if (next_state == START) seq_start_addr_o <= addr_sel;
      rd_valid_o  <= rd_hit ? onehot(owner_q) : '0;
      if (rd_hit) rd_data_o <= seq_data_i;
    end
  end

endmodule

// File: tb/tb_bus_seq_arbiter.sv
// Directed bench for bus_seq_arbiter: the bench plays the sequencer and checks
// grants, routing, watchdog and reset behaviour against hand-derived values.
module tb_bus_seq_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 32;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ-1:0]        gnt_o;
  logic [NUM_REQ-1:0]        done_o;
  logic [NUM_REQ-1:0]        err_o;
  logic [NUM_REQ-1:0]        rd_valid_o;
  logic [7:0]                rd_data_o;
  logic                      busy_o;
  logic                      seq_start_o;
  logic [ADDR_W-1:0]         seq_start_addr_o;
  logic                      seq_ready_i;
  logic                      seq_data_valid_i;
  logic [7:0]                seq_data_i;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] job_bytes [0:3];

  bus_seq_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .ADDR_W     (ADDR_W),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_i           (req_i),
    .req_addr_i      (req_addr_i),
    .gnt_o           (gnt_o),
    .done_o          (done_o),
    .err_o           (err_o),
    .rd_valid_o      (rd_valid_o),
    .rd_data_o       (rd_data_o),
    .busy_o          (busy_o),
    .seq_start_o     (seq_start_o),
    .seq_start_addr_o(seq_start_addr_o),
    .seq_ready_i     (seq_ready_i),
    .seq_data_valid_i(seq_data_valid_i),
    .seq_data_i      (seq_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addr_of(input int n);
    return 32'h100 + 32'(n * 16);
  endfunction

  task automatic set_addrs();
    for (int n = 0; n < NUM_REQ; n++) req_addr_i[n*ADDR_W +: ADDR_W] = addr_of(n);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req_i = '0;
    seq_ready_i = 1'b1;
    seq_data_valid_i = 1'b0;
    seq_data_i = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Wait for start, then act as a sequencer: hold ready for drop_dly cycles,
  // go busy for busy_len cycles emitting nbytes bytes, then finish.
  task automatic run_job(input int owner, input int drop_dly, input int busy_len,
                         input int nbytes, input bit drop_req, input int exp_lat);
    int               lat;
    logic [NUM_REQ-1:0] oh;
    oh  = 4'b0001 << owner;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!seq_start_o && lat < 40);
    check("start_seen", 32'(seq_start_o), 32'd1);
    if (exp_lat > 0) check("grant_latency", lat, exp_lat);
    check("gnt_owner", 32'(gnt_o), 32'(oh));
    check("start_addr", seq_start_addr_o, addr_of(owner));
    check("busy_run", 32'(busy_o), 32'd1);
    if (drop_req) req_i = '0;
    for (int d = 0; d < drop_dly; d++) tick();
    check("start_single_pulse", 32'(seq_start_o), 32'd0);
    seq_ready_i = 1'b0;
    for (int b = 0; b < busy_len; b++) begin
      seq_data_valid_i = (b < nbytes);
      seq_data_i       = (b < nbytes) ? job_bytes[b] : 8'h00;
      tick();
      check("rd_valid", 32'(rd_valid_o), (b < nbytes) ? 32'(oh) : 32'd0);
      if (b < nbytes) check("rd_data", 32'(rd_data_o), 32'(job_bytes[b]));
    end
    seq_data_valid_i = 1'b0;
    seq_ready_i      = 1'b1;
    tick();
    check("done_pulse", 32'(done_o), 32'(oh));
    check("err_clear", 32'(err_o), 32'd0);
    check("gnt_in_done", 32'(gnt_o), 32'(oh));
    tick();
    check("done_cleared", 32'(done_o), 32'd0);
    check("gnt_cleared", 32'(gnt_o), 32'd0);
    check("busy_idle", 32'(busy_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench timeout");
  end

  initial begin
    int lat;
    int cnt;
    rst = 1'b1;
    req_addr_i = '0;
    set_addrs();
    apply_reset();

    check("rst_gnt", 32'(gnt_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_start", 32'(seq_start_o), 32'd0);
    check("rst_addr", seq_start_addr_o, 32'd0);

    // Single requester, request dropped mid-job, address changed after sampling
    req_i = 4'b0001;
    run_job(0, 2, 10, 0, 1'b1, 1);
    req_addr_i[0 +: ADDR_W] = 32'hDEAD_BEEF;
    tick();
    check("addr_held", seq_start_addr_o, 32'h100);
    set_addrs();

    // All four requesting: strict rotation from pointer 0
    apply_reset();
    req_i = 4'b1111;
    for (int j = 0; j < 8; j++) run_job(j % 4, 1, 2, 0, 1'b0, 1);

    // Read routing to requester 2
    req_i = 4'b0100;
    job_bytes[0] = 8'hA5;
    job_bytes[1] = 8'h5A;
    job_bytes[2] = 8'hFF;
    job_bytes[3] = 8'h00;
    run_job(2, 2, 4, 3, 1'b1, 1);

    // Watchdog: sequencer never drops ready; ptr=3 so requester 0 wins first
    req_i = 4'b0011;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!seq_start_o && lat < 40);
    check("to_start_seen", 32'(seq_start_o), 32'd1);
    check("to_gnt", 32'(gnt_o), 32'b0001);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!done_o[0] && cnt < 40);
    check("to_latency", cnt, 18);
    check("to_done", 32'(done_o), 32'b0001);
    check("to_err", 32'(err_o), 32'b0001);
    tick();
    check("to_err_cleared", 32'(err_o), 32'd0);
    check("to_gnt_cleared", 32'(gnt_o), 32'd0);
    run_job(1, 1, 3, 0, 1'b1, 1);

    // Sequencer not ready while idle: no grant; stray read valid is dropped
    req_i = 4'b0010;
    seq_ready_i = 1'b0;
    seq_data_valid_i = 1'b1;
    seq_data_i = 8'h3C;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("noready_start", 32'(seq_start_o), 32'd0);
    end
    check("noready_busy", 32'(busy_o), 32'd0);
    check("idle_rd_dropped", 32'(rd_valid_o), 32'd0);
    seq_data_valid_i = 1'b0;
    seq_ready_i = 1'b1;
    run_job(1, 1, 2, 0, 1'b1, 1);

    // Reset during RUN
    req_i = 4'b0100;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!seq_start_o && lat < 40);
    check("rr_start_seen", 32'(seq_start_o), 32'd1);
    check("rr_gnt", 32'(gnt_o), 32'b0100);
    req_i = '0;
    tick();
    tick();
    seq_ready_i = 1'b0;
    tick();
    tick();
    check("rr_busy_before", 32'(busy_o), 32'd1);
    rst = 1'b1;
    #1;
    check("rr_gnt_zero", 32'(gnt_o), 32'd0);
    check("rr_busy_zero", 32'(busy_o), 32'd0);
    check("rr_start_zero", 32'(seq_start_o), 32'd0);
    check("rr_addr_zero", seq_start_addr_o, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    seq_ready_i = 1'b1;
    req_i = 4'b1000;
    run_job(3, 2, 3, 0, 1'b1, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
